id_ex_hazard_stage: RTL and testbench

- ID→EX→MEM control pipeline for the 5-stage LEGv8 core.
- Registers destination/control fields that the forwarding logic consumes: Rd_EX, RegWrite_EX, setFlag_EX, Rd_MEM, RegWrite_MEM.
- Detects load-use hazards against the instruction in ID, inserts a one-cycle bubble, and holds PC and IF/ID.
- Generates the IF/ID flush for taken branches resolved in ID, and keeps saturating stall and flush counters for performance readout.

---
 rtl/id_ex_hazard_if.sv | 46 ++++
 rtl/id_ex_hazard_stage.sv | 129 ++++++++++++
 tb/tb_id_ex_hazard_stage.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_hazard_if.sv
// ID/EX/MEM control bundle between the decode stage and the hazard/pipeline
// register block. The decode side (master) drives the *_ID fields and
// consumes the registered EX/MEM fields plus the stall/flush controls.
interface id_ex_hazard_if #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
);
   // Decode-stage instruction fields
   logic [REG_W-1:0] Rn_ID;
   logic [REG_W-1:0] Rm_ID;
   logic             usesRn_ID;
   logic             usesRm_ID;
   logic [REG_W-1:0] Rd_ID;
   logic             RegWrite_ID;
   logic             MemRead_ID;
   logic             setFlag_ID;
   logic             branch_taken_ID;

   // Registered downstream fields consumed by forwarding
   logic [REG_W-1:0] Rd_EX;
   logic             RegWrite_EX;
   logic             MemRead_EX;
   logic             setFlag_EX;
   logic [REG_W-1:0] Rd_MEM;
   logic             RegWrite_MEM;

   // Front-end control and performance readout
   logic             stall;
   logic             flush_IF;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output Rn_ID, Rm_ID, usesRn_ID, usesRm_ID, Rd_ID,
             RegWrite_ID, MemRead_ID, setFlag_ID, branch_taken_ID,
      input  Rd_EX, RegWrite_EX, MemRead_EX, setFlag_EX, Rd_MEM, RegWrite_MEM,
             stall, flush_IF, stall_count, flush_count
   );

   modport slave (
      input  Rn_ID, Rm_ID, usesRn_ID, usesRm_ID, Rd_ID,
             RegWrite_ID, MemRead_ID, setFlag_ID, branch_taken_ID,
      output Rd_EX, RegWrite_EX, MemRead_EX, setFlag_EX, Rd_MEM, RegWrite_MEM,
             stall, flush_IF, stall_count, flush_count
   );
endinterface

// File: rtl/id_ex_hazard_stage.sv
// ID->EX->MEM control pipeline registers with load-use hazard detection,
// branch flush generation and saturating stall/flush performance counters.
module id_ex_hazard_stage #(
   parameter int REG_W    = 5,
   parameter int CNT_W    = 16,
   parameter int ZERO_REG = 31
) (
   input  logic             clk,
   input  logic             reset,
   id_ex_hazard_if.slave    bus
);

   localparam logic [REG_W-1:0] ZR      = REG_W'(ZERO_REG);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {
      RUN,
      LOAD_STALL
   } state_t;

   state_t           state_q, state_d;

   logic [REG_W-1:0] rd_ex_q, rd_ex_d;
   logic             regwrite_ex_q, regwrite_ex_d;
   logic             memread_ex_q, memread_ex_d;
   logic             setflag_ex_q, setflag_ex_d;
   logic [REG_W-1:0] rd_mem_q, rd_mem_d;
   logic             regwrite_mem_q, regwrite_mem_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic [CNT_W-1:0] flush_count_q, flush_count_d;

   logic             hz;
   logic             stall;
   logic             flush;
   logic             rn_match;
   logic             rm_match;

   // Load-use hazard: EX holds a load whose result the ID instruction reads.
   // XZR is never a real producer, and reset masks the front-end controls.
   always_comb begin
      rn_match = bus.usesRn_ID & (bus.Rn_ID == rd_ex_q);
      rm_match = bus.usesRm_ID & (bus.Rm_ID == rd_ex_q);
      hz       = memread_ex_q & regwrite_ex_q & (rd_ex_q != ZR) & (rn_match | rm_match);
      stall    = hz & ~reset;
      // A branch resolved on stale operands is not trusted, so stall wins.
      flush    = bus.branch_taken_ID & ~stall & ~reset;
   end

   // EX captures ID or a bubble on stall; MEM always follows EX.
   always_comb begin
      if (stall) begin
         rd_ex_d       = ZR;
         regwrite_ex_d = 1'b0;
         memread_ex_d  = 1'b0;
         setflag_ex_d  = 1'b0;
      end else begin
         rd_ex_d       = bus.Rd_ID;
         regwrite_ex_d = bus.RegWrite_ID;
         memread_ex_d  = bus.MemRead_ID;
         setflag_ex_d  = bus.setFlag_ID;
      end
      rd_mem_d       = rd_ex_q;
      regwrite_mem_d = regwrite_ex_q;
   end

   // Performance counters saturate at all-ones rather than wrapping.
   always_comb begin
      stall_count_d = stall_count_q;
      flush_count_d = flush_count_q;
      if (stall && (stall_count_q != CNT_MAX)) begin
         stall_count_d = stall_count_q + 1'b1;
      end
      if (flush && (flush_count_q != CNT_MAX)) begin
         flush_count_d = flush_count_q + 1'b1;
      end
   end

   // Stall tracker: a stall lasts exactly one cycle because EX then holds a bubble.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:        if (stall) state_d = LOAD_STALL;
         LOAD_STALL: state_d = RUN;
         default:    state_d = RUN;
      endcase
   end

   // State registers with synchronous reset to an empty (XZR, no-write) pipeline.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= RUN;
         rd_ex_q        <= ZR;
         regwrite_ex_q  <= 1'b0;
         memread_ex_q   <= 1'b0;
         setflag_ex_q   <= 1'b0;
         rd_mem_q       <= ZR;
         regwrite_mem_q <= 1'b0;
         stall_count_q  <= '0;
         flush_count_q  <= '0;
      end else begin
         state_q        <= state_d;
         rd_ex_q        <= rd_ex_d;
         regwrite_ex_q  <= regwrite_ex_d;
         memread_ex_q   <= memread_ex_d;
         setflag_ex_q   <= setflag_ex_d;
         rd_mem_q       <= rd_mem_d;
         regwrite_mem_q <= regwrite_mem_d;
         stall_count_q  <= stall_count_d;
         flush_count_q  <= flush_count_d;
      end
   end

   // A hazard seen while the bubble is in EX means the bubble logic is broken.
   a_no_stall_in_load_stall : assert property (
      @(posedge clk) disable iff (reset) (state_q == LOAD_STALL) |-> !hz
   );

   assign bus.Rd_EX        = rd_ex_q;
   assign bus.RegWrite_EX  = regwrite_ex_q;
   assign bus.MemRead_EX   = memread_ex_q;
   assign bus.setFlag_EX   = setflag_ex_q;
   assign bus.Rd_MEM       = rd_mem_q;
   assign bus.RegWrite_MEM = regwrite_mem_q;
   assign bus.stall        = stall;
   assign bus.flush_IF     = flush;
   assign bus.stall_count  = stall_count_q;
   assign bus.flush_count  = flush_count_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Bench for id_ex_hazard_stage: two instances (16-bit and 4-bit counters)
// share one directed stimulus stream; a record-level pipeline model is
// compared every cycle, plus literal checks at key points.
module tb_id_ex_hazard_stage;

   logic clk;
   logic reset;

   logic [4:0] rn, rm, rd;
   logic       urn, urm, rw, mr, sf, br;

   int n_tests = 0;
   int n_fail  = 0;

   id_ex_hazard_if #(.REG_W(5), .CNT_W(16)) bus16 ();
   id_ex_hazard_if #(.REG_W(5), .CNT_W(4))  bus4 ();

   assign bus16.Rn_ID = rn;  assign bus4.Rn_ID = rn;
   assign bus16.Rm_ID = rm;  assign bus4.Rm_ID = rm;
   assign bus16.usesRn_ID = urn;  assign bus4.usesRn_ID = urn;
   assign bus16.usesRm_ID = urm;  assign bus4.usesRm_ID = urm;
   assign bus16.Rd_ID = rd;  assign bus4.Rd_ID = rd;
   assign bus16.RegWrite_ID = rw;  assign bus4.RegWrite_ID = rw;
   assign bus16.MemRead_ID = mr;   assign bus4.MemRead_ID = mr;
   assign bus16.setFlag_ID = sf;   assign bus4.setFlag_ID = sf;
   assign bus16.branch_taken_ID = br;  assign bus4.branch_taken_ID = br;

   id_ex_hazard_stage #(.REG_W(5), .CNT_W(16), .ZERO_REG(31)) dut16 (
      .clk(clk), .reset(reset), .bus(bus16)
   );
   id_ex_hazard_stage #(.REG_W(5), .CNT_W(4), .ZERO_REG(31)) dut4 (
      .clk(clk), .reset(reset), .bus(bus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each pipeline slot is an instruction record; a stall replaces the
   // record entering EX with a no-op that writes nothing to XZR.
   typedef struct {
      logic [4:0] rd;
      logic       rw;
      logic       mr;
      logic       sf;
   } rec_t;

   rec_t m_ex, m_mem;
   int   m_sc16, m_fc16, m_sc4, m_fc4;
   bit   m_valid = 1'b0;

   function automatic logic m_stall();
      logic reads;
      reads = (urn && rn == m_ex.rd) || (urm && rm == m_ex.rd);
      return !reset && m_ex.mr && m_ex.rw && (m_ex.rd != 5'd31) && reads;
   endfunction

   function automatic logic m_flush();
      return !reset && br && !m_stall();
   endfunction

   function automatic int sat_inc(input int v, input int maxv);
      return (v < maxv) ? v + 1 : v;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_valid <= 1'b1;
         m_ex    <= '{rd: 5'd31, rw: 1'b0, mr: 1'b0, sf: 1'b0};
         m_mem   <= '{rd: 5'd31, rw: 1'b0, mr: 1'b0, sf: 1'b0};
         m_sc16  <= 0; m_fc16 <= 0; m_sc4 <= 0; m_fc4 <= 0;
      end else begin
         if (m_stall()) m_ex <= '{rd: 5'd31, rw: 1'b0, mr: 1'b0, sf: 1'b0};
         else           m_ex <= '{rd: rd, rw: rw, mr: mr, sf: sf};
         m_mem <= m_ex;
         if (m_stall()) begin
            m_sc16 <= sat_inc(m_sc16, 65535);
            m_sc4  <= sat_inc(m_sc4, 15);
         end
         if (m_flush()) begin
            m_fc16 <= sat_inc(m_fc16, 65535);
            m_fc4  <= sat_inc(m_fc4, 15);
         end
      end
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("Rd_EX16",        32'(bus16.Rd_EX),        32'(m_ex.rd));
         chk("RegWrite_EX16",  32'(bus16.RegWrite_EX),  32'(m_ex.rw));
         chk("MemRead_EX16",   32'(bus16.MemRead_EX),   32'(m_ex.mr));
         chk("setFlag_EX16",   32'(bus16.setFlag_EX),   32'(m_ex.sf));
         chk("Rd_MEM16",       32'(bus16.Rd_MEM),       32'(m_mem.rd));
         chk("RegWrite_MEM16", 32'(bus16.RegWrite_MEM), 32'(m_mem.rw));
         chk("stall16",        32'(bus16.stall),        32'(m_stall()));
         chk("flush16",        32'(bus16.flush_IF),     32'(m_flush()));
         chk("stall_count16",  32'(bus16.stall_count),  32'(m_sc16));
         chk("flush_count16",  32'(bus16.flush_count),  32'(m_fc16));
         chk("Rd_EX4",         32'(bus4.Rd_EX),         32'(m_ex.rd));
         chk("Rd_MEM4",        32'(bus4.Rd_MEM),        32'(m_mem.rd));
         chk("stall4",         32'(bus4.stall),         32'(m_stall()));
         chk("flush4",         32'(bus4.flush_IF),      32'(m_flush()));
         chk("stall_count4",   32'(bus4.stall_count),   32'(m_sc4));
         chk("flush_count4",   32'(bus4.flush_count),   32'(m_fc4));
      end
   end

   // ---------------- directed stimulus ----------------
   // Apply one ID instruction just after a rising edge, return at the falling edge.
   task automatic drive(input logic [4:0] a_rn, input logic a_urn,
                        input logic [4:0] a_rm, input logic a_urm,
                        input logic [4:0] a_rd, input logic a_rw,
                        input logic a_mr, input logic a_sf, input logic a_br);
      @(posedge clk);
      #1;
      rn = a_rn; urn = a_urn; rm = a_rm; urm = a_urm;
      rd = a_rd; rw = a_rw; mr = a_mr; sf = a_sf; br = a_br;
      @(negedge clk);
   endtask

   task automatic nop();
      drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic ldur(input logic [4:0] d);
      drive(5'd1, 1'b1, 5'd0, 1'b0, d, 1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      rn = 0; rm = 0; urn = 0; urm = 0; rd = 5'd31; rw = 0; mr = 0; sf = 0; br = 0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rst.Rd_EX",       32'(bus16.Rd_EX),       32'd31);
      chk("rst.Rd_MEM",      32'(bus16.Rd_MEM),      32'd31);
      chk("rst.RegWrite_EX", 32'(bus16.RegWrite_EX), 32'd0);
      chk("rst.stall_count", 32'(bus16.stall_count), 32'd0);
      chk("rst.stall",       32'(bus16.stall),       32'd0);

      #2 reset = 1'b0;
      // LDUR X2 then ADD X3, X2, ...: one stall, bubble, then X2 reaches MEM.
      ldur(5'd2);
      drive(5'd2, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("lu.stall", 32'(bus16.stall), 32'd1);
      drive(5'd2, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("lu.stall_once",   32'(bus16.stall),        32'd0);
      chk("lu.RegWrite_EX",  32'(bus16.RegWrite_EX),  32'd0);
      chk("lu.Rd_EX",        32'(bus16.Rd_EX),        32'd31);
      chk("lu.RegWrite_MEM", 32'(bus16.RegWrite_MEM), 32'd1);
      chk("lu.Rd_MEM",       32'(bus16.Rd_MEM),       32'd2);
      chk("lu.stall_count",  32'(bus16.stall_count),  32'd1);
      nop();
      chk("lu.add_Rd_EX", 32'(bus16.Rd_EX), 32'd3);

      // No-hazard cases: XZR destination, different register, unused source.
      ldur(5'd31);
      drive(5'd31, 1'b1, 5'd31, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("xzr.stall", 32'(bus16.stall), 32'd0);
      ldur(5'd5);
      drive(5'd6, 1'b1, 5'd6, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("diff.stall", 32'(bus16.stall), 32'd0);
      ldur(5'd8);
      drive(5'd8, 1'b0, 5'd8, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("unused.stall", 32'(bus16.stall), 32'd0);

      // Hazard through the Rm port (STUR data register).
      ldur(5'd7);
      drive(5'd1, 1'b1, 5'd7, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rm.stall", 32'(bus16.stall), 32'd1);
      drive(5'd1, 1'b1, 5'd7, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rm.stall_once", 32'(bus16.stall), 32'd0);

      // Branch coincident with a load-use hazard: stall wins, flush follows.
      ldur(5'd9);
      drive(5'd0, 1'b0, 5'd9, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("br.stall", 32'(bus16.stall),    32'd1);
      chk("br.flush", 32'(bus16.flush_IF), 32'd0);
      drive(5'd0, 1'b0, 5'd9, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("br.flush_next", 32'(bus16.flush_IF), 32'd1);
      nop();
      chk("br.flush_count", 32'(bus16.flush_count), 32'd1);
      chk("br.stall_count", 32'(bus16.stall_count), 32'd3);

      // ADDS X4: flags and destination flow EX then MEM.
      drive(5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
      nop();
      chk("adds.setFlag_EX", 32'(bus16.setFlag_EX), 32'd1);
      chk("adds.Rd_EX",      32'(bus16.Rd_EX),      32'd4);
      nop();
      chk("adds.Rd_MEM",     32'(bus16.Rd_MEM),     32'd4);
      chk("adds.setFlag_EX0", 32'(bus16.setFlag_EX), 32'd0);

      // Hazards as dense as the pipeline allows: 19 more stalls.
      for (int i = 0; i < 19; i++) begin
         ldur(5'd10);
         drive(5'd10, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      nop();
      chk("sat.stall_count4",  32'(bus4.stall_count),  32'd15);
      chk("sat.stall_count16", 32'(bus16.stall_count), 32'd22);

      // Reset arriving in the stall cycle.
      ldur(5'd12);
      @(posedge clk);
      #1;
      rn = 5'd12; urn = 1'b1; rm = 0; urm = 0; rd = 5'd13; rw = 1; mr = 0; sf = 0; br = 1;
      reset = 1'b1;
      @(negedge clk);
      chk("mid.stall_masked", 32'(bus16.stall),    32'd0);
      chk("mid.flush_masked", 32'(bus16.flush_IF), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      rn = 0; urn = 0; rd = 5'd31; rw = 0; br = 0;
      @(negedge clk);
      chk("mid.stall_count4",  32'(bus4.stall_count),  32'd0);
      chk("mid.stall_count16", 32'(bus16.stall_count), 32'd0);
      chk("mid.flush_count16", 32'(bus16.flush_count), 32'd0);
      chk("mid.Rd_EX",         32'(bus16.Rd_EX),       32'd31);
      chk("mid.MemRead_EX",    32'(bus16.MemRead_EX),  32'd0);

      // Normal operation resumes after reset.
      ldur(5'd14);
      drive(5'd14, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("post.stall", 32'(bus16.stall), 32'd1);
      nop();
      nop();
      chk("post.stall_count", 32'(bus16.stall_count), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
